// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared mode-FSM encodings and requester IDs
package mem_arbiter_pkg;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_PROG  = 2'd2;
    localparam logic       ID_CU    = 1'b0;
    localparam logic       ID_PG    = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, pointer remembers the last granted requester
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic last_q, last_d;
    // Lone requester wins; on a tie the one not granted last wins
    always_comb begin
        gnt_o[0] = req_i[0] & (!req_i[1] | (last_q == ID_PG));
        gnt_o[1] = req_i[1] & (!req_i[0] | (last_q == ID_CU));
        last_d   = gnt_o[1] ? ID_PG : gnt_o[0] ? ID_CU : last_q;
    end
    // Pointer moves only when a grant (and hence a transfer) happens
    always_ff @(posedge clk_i) begin
        if (!reset_i) last_q <= ID_PG;
        else          last_q <= last_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between control unit and programmer, with a drained programming mode
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            prog_mode_i,
    input  logic                            cu_req_i,
    input  logic                            cu_we_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] cu_addr_i,
    input  logic [REGISTER_WIDTH-1:0]       cu_wdata_i,
    output logic                            cu_gnt_o,
    output logic                            cu_rvalid_o,
    output logic [REGISTER_WIDTH-1:0]       cu_rdata_o,
    input  logic                            pg_req_i,
    input  logic                            pg_we_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0] pg_addr_i,
    input  logic [REGISTER_WIDTH-1:0]       pg_wdata_i,
    output logic                            pg_gnt_o,
    output logic                            pg_rvalid_o,
    output logic [REGISTER_WIDTH-1:0]       pg_rdata_o,
    output logic                            mem_read_en_o,
    output logic                            mem_write_en_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [REGISTER_WIDTH-1:0]       mem_wdata_o,
    input  logic [REGISTER_WIDTH-1:0]       mem_rdata_i,
    output logic                            prog_busy_o,
    output logic [MEMORY_ADDRESS_WIDTH:0]   pg_wr_count_o
);
    localparam logic [MEMORY_ADDRESS_WIDTH:0] CNT_MAX = {1'b1, {MEMORY_ADDRESS_WIDTH{1'b0}}};
    logic [1:0]                      state_q, state_d;
    logic                            cu_rd_q, cu_rd_d, pg_rd_q, pg_rd_d;
    logic [MEMORY_ADDRESS_WIDTH:0]   cnt_q, cnt_d;
    logic [1:0]                      gnt;
    logic                            win, win_we;
    rr_arbiter2 u_rr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .req_i  ({pg_req_i & (state_q != ST_DRAIN), cu_req_i & (state_q == ST_RUN)}),
        .gnt_o  (gnt)
    );
    // Route the winner onto the memory port, track reads and advance the mode FSM
    always_comb begin
        win            = |gnt;
        win_we         = gnt[1] ? pg_we_i : cu_we_i;
        mem_write_en_o = win & win_we;
        mem_read_en_o  = win & !win_we;
        mem_addr_o     = gnt[1] ? pg_addr_i : gnt[0] ? cu_addr_i : '0;
        mem_wdata_o    = gnt[1] ? pg_wdata_i : gnt[0] ? cu_wdata_i : '0;
        cu_rd_d        = gnt[0] & !cu_we_i;
        pg_rd_d        = gnt[1] & !pg_we_i;
        state_d        = (state_q == ST_RUN)   ? (prog_mode_i ? ST_DRAIN : ST_RUN)
                       : (state_q == ST_DRAIN) ? (!prog_mode_i ? ST_RUN : (cu_rd_q | pg_rd_q) ? ST_DRAIN : ST_PROG)
                       : (state_q == ST_PROG && prog_mode_i) ? ST_PROG : ST_RUN;
        cnt_d          = (state_q == ST_DRAIN && state_d == ST_PROG) ? '0
                       : (state_q == ST_PROG && gnt[1] && pg_we_i && cnt_q != CNT_MAX) ? cnt_q + 1'b1
                       : cnt_q;
    end
    // State, outstanding-read flags and the session write counter
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_RUN;
            cu_rd_q <= 1'b0;
            pg_rd_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cu_rd_q <= cu_rd_d;
            pg_rd_q <= pg_rd_d;
            cnt_q   <= cnt_d;
        end
    end
    assign cu_gnt_o      = gnt[0];
    assign pg_gnt_o      = gnt[1];
    assign cu_rvalid_o   = cu_rd_q;
    assign pg_rvalid_o   = pg_rd_q;
    assign cu_rdata_o    = cu_rd_q ? mem_rdata_i : '0;
    assign pg_rdata_o    = pg_rd_q ? mem_rdata_i : '0;
    assign prog_busy_o   = (state_q == ST_DRAIN) | (state_q == ST_PROG);
    assign pg_wr_count_o = cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, read return, drain/program modes and reset
module tb_mem_arbiter;
    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       prog_mode_i = 1'b0;
    logic       cu_req_i = 1'b0, cu_we_i = 1'b0, pg_req_i = 1'b0, pg_we_i = 1'b0;
    logic [3:0] cu_addr_i = '0, cu_wdata_i = '0, pg_addr_i = '0, pg_wdata_i = '0;
    logic       cu_gnt_o, cu_rvalid_o, pg_gnt_o, pg_rvalid_o;
    logic [3:0] cu_rdata_o, pg_rdata_o;
    logic       mem_read_en_o, mem_write_en_o, prog_busy_o;
    logic [3:0] mem_addr_o, mem_wdata_o;
    logic [3:0] mem_rdata_i = '0;
    logic [4:0] pg_wr_count_o;
    logic [3:0] mem [16];
    int         tests = 0, failed = 0;

    mem_arbiter #(.REGISTER_WIDTH(4), .MEMORY_ADDRESS_WIDTH(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .prog_mode_i(prog_mode_i),
        .cu_req_i(cu_req_i), .cu_we_i(cu_we_i), .cu_addr_i(cu_addr_i), .cu_wdata_i(cu_wdata_i),
        .cu_gnt_o(cu_gnt_o), .cu_rvalid_o(cu_rvalid_o), .cu_rdata_o(cu_rdata_o),
        .pg_req_i(pg_req_i), .pg_we_i(pg_we_i), .pg_addr_i(pg_addr_i), .pg_wdata_i(pg_wdata_i),
        .pg_gnt_o(pg_gnt_o), .pg_rvalid_o(pg_rvalid_o), .pg_rdata_o(pg_rdata_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .prog_busy_o(prog_busy_o), .pg_wr_count_o(pg_wr_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: mem[i] = 3*i after reset, one-cycle read latency
    always @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i * 3);
        end else if (mem_write_en_o) mem[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= mem_read_en_o ? mem[mem_addr_o] : 4'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        tick; tick;
        check("rst_cu_rvalid", cu_rvalid_o, 0);
        check("rst_pg_rvalid", pg_rvalid_o, 0);
        check("rst_busy", prog_busy_o, 0);
        check("rst_count", pg_wr_count_o, 0);
        check("rst_cu_rdata", cu_rdata_o, 0);
        reset_i = 1'b1;
        tick;
        // simultaneous read of addr 3: cu first, then pg
        cu_req_i = 1; cu_we_i = 0; cu_addr_i = 3;
        pg_req_i = 1; pg_we_i = 0; pg_addr_i = 3;
        #1;
        check("tie_cu_gnt", cu_gnt_o, 1);
        check("tie_pg_gnt0", pg_gnt_o, 0);
        check("tie_rd_en", mem_read_en_o, 1);
        check("tie_addr", mem_addr_o, 3);
        tick; cu_req_i = 0; #1;
        check("cu_rvalid", cu_rvalid_o, 1);
        check("cu_rdata3", cu_rdata_o, 4'h9);
        check("pg_gnt_next", pg_gnt_o, 1);
        tick; pg_req_i = 0; #1;
        check("pg_rvalid", pg_rvalid_o, 1);
        check("pg_rdata3", pg_rdata_o, 4'h9);
        check("cu_rvalid_off", cu_rvalid_o, 0);
        check("cu_rdata_zero", cu_rdata_o, 0);
        // cu writes 0xA to 5 then reads it back
        cu_req_i = 1; cu_we_i = 1; cu_addr_i = 5; cu_wdata_i = 4'hA; #1;
        check("wr_en", mem_write_en_o, 1);
        check("wr_rd_en", mem_read_en_o, 0);
        check("wr_addr", mem_addr_o, 5);
        check("wr_data", mem_wdata_o, 4'hA);
        tick; cu_we_i = 0; #1;
        check("rd5_en", mem_read_en_o, 1);
        tick; cu_req_i = 0; #1;
        check("rd5_rvalid", cu_rvalid_o, 1);
        check("rd5_rdata", cu_rdata_o, 4'hA);
        check("rd5_pg_rvalid", pg_rvalid_o, 0);
        check("idle_addr", mem_addr_o, 0);
        check("idle_wr", mem_write_en_o, 0);
        // cu was granted last, so pg wins this tie
        cu_req_i = 1; pg_req_i = 1; pg_we_i = 0; cu_addr_i = 0; pg_addr_i = 0; #1;
        check("tie2_pg_gnt", pg_gnt_o, 1);
        check("tie2_cu_gnt", cu_gnt_o, 0);
        tick; pg_req_i = 0; #1;
        check("tie2_cu_next", cu_gnt_o, 1);
        tick; cu_req_i = 0; tick;
        // read in flight when prog mode rises
        cu_req_i = 1; cu_addr_i = 3; prog_mode_i = 1; #1;
        check("drn_cu_gnt", cu_gnt_o, 1);
        tick; cu_req_i = 0;
        pg_req_i = 1; pg_we_i = 1; pg_addr_i = 0; pg_wdata_i = 4'hF; #1;
        check("drn_busy", prog_busy_o, 1);
        check("drn_cu_rvalid", cu_rvalid_o, 1);
        check("drn_cu_rdata", cu_rdata_o, 4'h9);
        check("drn_no_pg_gnt", pg_gnt_o, 0);
        tick;
        check("drn2_no_pg_gnt", pg_gnt_o, 0);
        check("drn2_cu_rvalid", cu_rvalid_o, 0);
        cu_req_i = 1; cu_we_i = 0; cu_addr_i = 7;
        tick;
        check("prog_busy", prog_busy_o, 1);
        check("prog_count0", pg_wr_count_o, 0);
        // sixteen programmer writes while cu keeps requesting
        for (int i = 0; i < 16; i++) begin
            pg_addr_i = 4'(i); pg_wdata_i = 4'(15 - i); #1;
            check("prog_pg_gnt", pg_gnt_o, 1);
            check("prog_cu_gnt", cu_gnt_o, 0);
            tick;
        end
        check("prog_count16", pg_wr_count_o, 16);
        tick;
        check("prog_count_sat", pg_wr_count_o, 16);
        check("prog_mem_wr", mem[2], 4'hD);
        pg_req_i = 0; prog_mode_i = 0; #1;
        check("prog_last_cu_gnt", cu_gnt_o, 0);
        tick;
        check("run_busy", prog_busy_o, 0);
        check("run_cu_gnt", cu_gnt_o, 1);
        check("run_count_kept", pg_wr_count_o, 16);
        tick; cu_req_i = 0;
        // abort from DRAIN
        prog_mode_i = 1; tick;
        check("abort_busy", prog_busy_o, 1);
        prog_mode_i = 0; tick;
        check("abort_run", prog_busy_o, 0);
        check("abort_count", pg_wr_count_o, 16);
        // reset with a pg read outstanding
        pg_req_i = 1; pg_we_i = 0; pg_addr_i = 3; tick;
        pg_req_i = 0; reset_i = 0; #1;
        check("pre_rst_pg_rvalid", pg_rvalid_o, 1);
        tick;
        check("mid_rst_pg_rvalid", pg_rvalid_o, 0);
        check("mid_rst_pg_rdata", pg_rdata_o, 0);
        check("mid_rst_count", pg_wr_count_o, 0);
        check("mid_rst_busy", prog_busy_o, 0);
        reset_i = 1; tick;
        cu_req_i = 1; pg_req_i = 1; #1;
        check("post_rst_cu_gnt", cu_gnt_o, 1);
        check("post_rst_pg_gnt", pg_gnt_o, 0);
        tick; cu_req_i = 0; pg_req_i = 0; tick;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 4, data width of memory words.
REQ-002 SHALL have parameter MEMORY_ADDRESS_WIDTH, default 4, memory address width.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk_i  in  1  system clock; all state updates on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-low reset.
REQ-006 prog_mode_i  in  1  high requests the programming session, giving the programmer exclusive memory access.
REQ-007 cu_req_i, cu_we_i  in  1 each  control-unit access request; we=1 write, we=0 read.
REQ-008 cu_addr_i  in  MEMORY_ADDRESS_WIDTH; cu_wdata_i  in  REGISTER_WIDTH  control-unit address and write data.
REQ-009 cu_gnt_o  out  1; cu_rvalid_o  out  1; cu_rdata_o  out  REGISTER_WIDTH  control-unit grant, read strobe and read data.
REQ-010 pg_req_i, pg_we_i, pg_addr_i, pg_wdata_i, pg_gnt_o, pg_rvalid_o, pg_rdata_o  SHALL mirror the cu_* ports for the programmer.
REQ-011 mem_read_en_o, mem_write_en_o  out  1 each; mem_addr_o  out  MEMORY_ADDRESS_WIDTH; mem_wdata_o  out  REGISTER_WIDTH  memory command.
REQ-012 mem_rdata_i  in  REGISTER_WIDTH  memory read data, valid one cycle after mem_read_en_o.
REQ-013 prog_busy_o  out  1  high in the DRAIN and PROG states; pg_wr_count_o  out  MEMORY_ADDRESS_WIDTH+1  programmer writes accepted in the current session.

Function
REQ-014 A transfer SHALL occur in any cycle where req_i and gnt_o of the same requester are both high.
REQ-015 gnt_o SHALL be combinational from the current-cycle req_i, the mode state and the priority pointer; at most one gnt_o high per cycle.
REQ-016 The requester SHALL hold req/we/addr/wdata stable until it sees gnt high.
REQ-017 The memory command SHALL be driven combinationally from the winner: write_en=we, read_en=!we, addr and wdata passed through; all four SHALL be 0 when there is no winner.
REQ-018 Read data SHALL reach the issuing requester one cycle after the read transfer: rvalid high for exactly that one cycle, rdata=mem_rdata_i; the other requester's rvalid stays 0.
REQ-019 rdata_o SHALL be 0 whenever rvalid_o is 0.
REQ-020 Mode FSM states and transitions:
- RUN: on prog_mode_i=1, go to DRAIN.
- DRAIN: after one cycle with no read outstanding, go to PROG.
- PROG: on prog_mode_i=0, go to RUN.
REQ-021 RUN: if only one requester is requesting, it SHALL be granted; on a simultaneous request, the requester not granted last SHALL win; the pointer updates only on a transfer.
REQ-022 DRAIN: no grants SHALL be issued; a pending rvalid SHALL still be delivered.
REQ-023 PROG: only pg SHALL be grantable; cu_gnt_o SHALL stay 0 even while cu_req_i is held.
REQ-024 Entering PROG SHALL clear pg_wr_count_o to 0; each pg write transfer in PROG SHALL increment it, saturating at 2**MEMORY_ADDRESS_WIDTH.
REQ-025 prog_mode_i falling during DRAIN SHALL return the FSM to RUN the next cycle; the counter SHALL be unchanged.
REQ-026 Back-to-back transfers SHALL be supported (one per cycle, no bubbles).

Reset
REQ-027 Reset SHALL put the FSM in RUN, with the pointer at "pg granted last" (cu wins the first tie).
REQ-028 Reset SHALL clear the outstanding-read flags, pg_wr_count_o, prog_busy_o and all rvalid/rdata outputs to 0.
REQ-029 Reset asserted mid-read SHALL drop the pending rvalid.

Structure
REQ-030 FSM state encodings (RUN, DRAIN, PROG) and the requester IDs (CU=0, PG=1) SHALL live in the shared cpu package.
REQ-031 One sub-module, rr_arbiter2 (2-way round-robin arbiter with pointer), is natural; everything else is inline.

Verification
REQ-032 After reset, cu and pg both request a read at addr 3 in the same cycle -> cu_gnt_o=1 first, pg_gnt_o=1 the next cycle; each rvalid arrives 1 cycle after its grant carrying mem[3].
REQ-033 In RUN, cu writes 0xA to addr 5, then reads addr 5 -> mem_write_en_o=1 with addr 5 and data 0xA; on the following read, cu_rvalid_o=1 with cu_rdata_o=0xA and pg_rvalid_o=0.
REQ-034 cu issues a read, and prog_mode_i rises in the same cycle -> DRAIN lasts until cu_rvalid_o is delivered, then the FSM enters PROG with prog_busy_o=1.
REQ-035 In PROG, pg writes 16 times while cu_req_i is held high -> cu_gnt_o stays 0 throughout; pg_wr_count_o=16; a 17th write leaves it at 16.
REQ-036 prog_mode_i falls -> next cycle is RUN with prog_busy_o=0, and the waiting cu request is granted immediately.
REQ-037 reset_i=0 asserted the cycle after a pg read -> pg_rvalid_o=0, FSM in RUN, pg_wr_count_o=0.
